ram_banked: RTL and testbench
=============================

RAM_BANKED -- requirements
Module: ram_banked

Interface
REQ-001 Parameter NBANKS, default 2: number of 16K x 16 SPRAM banks; legal values 1, 2, 4.
REQ-002 Parameter INIT_ZERO, default 1: when 1, zero-fill all memory after reset before accepting requests.
REQ-003 Derived constant AW = 15 + log2(NBANKS): byte address width (16 for NBANKS=2).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_we  input  1  1 = byte write, 0 = byte read.
REQ-009 req_addr  input  AW  byte address.
REQ-010 req_wdata  input  8  write byte.
REQ-011 rsp_valid  output  1  read data valid, one-cycle pulse per read.
REQ-012 rsp_rdata  output  8  read data, registered.
REQ-013 init_done  output  1  high once the block is in RUN.

Function
REQ-014 Address map: req_addr[0] = byte lane (0 = bits 7:0, 1 = bits 15:8); req_addr[log2(NBANKS):1] = bank index; req_addr[AW-1:log2(NBANKS)+1] = 14-bit word address.
REQ-015 A request is accepted in a cycle where req_valid & req_ready = 1; one request per cycle maximum; back-to-back accepts allowed.
REQ-016 FSM states: INIT, RUN; reset enters INIT when INIT_ZERO=1, RUN when INIT_ZERO=0.
REQ-017 INIT: 14-bit counter from 0 to 16383; each cycle writes 16'h0000 to that word in all banks, all mask bits enabled; req_ready=0.
REQ-018 INIT -> RUN in the cycle after counter value 16383 is written; INIT therefore lasts exactly 16384 cycles.
REQ-019 RUN: req_ready=1 every cycle; init_done=1.
REQ-020 Accepted write: only the addressed bank is write-enabled; only the two mask bits of the addressed byte lane are set; the other byte of the word is unchanged.
REQ-021 Accepted read: rsp_valid=1 exactly one cycle after accept; rsp_rdata = addressed byte selected using bank/lane captured at accept.
REQ-022 Writes produce no response; rsp_valid=0 in the cycle after a write accept.
REQ-023 rsp_rdata holds its last value while rsp_valid=0.
REQ-024 Read of an address accepted the cycle after a write to it returns the new byte.
REQ-025 Per bank, CHIPSELECT high only when that bank is addressed by an accepted request or during INIT; otherwise low. STANDBY=0, SLEEP=0, POWEROFF=1 always.
REQ-026 req_* inputs are ignored while req_ready=0; no request is queued.

Reset
REQ-027 rst_n low asynchronously forces: req_ready=0, rsp_valid=0, rsp_rdata=8'h00, init_done=0, init counter=0, captured bank/lane=0.
REQ-028 With INIT_ZERO=1, reset asserted mid-INIT restarts INIT from word 0 after release.
REQ-029 With INIT_ZERO=1, reset asserted during RUN re-enters INIT; memory is re-zeroed.
REQ-030 With INIT_ZERO=0, reset does not modify memory contents; req_ready=1 from the first rising edge after release.

Structure
REQ-031 Shared package holds: legal NBANKS values, SPRAM word-address width (14), lane-to-mask mapping, FSM state encoding.
REQ-032 One sub-module, ram_bank, wraps one SB_SPRAM256KA: ports word address, 16-bit data in/out, 4-bit mask, write enable, chip select; ram_banked instantiates NBANKS copies.
REQ-033 Output byte mux is registered in ram_banked, not in ram_bank.

Verification
REQ-034 NBANKS=2, INIT_ZERO=1: release reset -> req_ready=0 for 16384 cycles, then req_ready=1 and init_done=1; read 0x0000, 0x7FFF, 0xFFFF -> 8'h00 each.
REQ-035 Write 0x1234<-8'hA5 then 0x1235<-8'h5A, read both -> A5 then 5A, each on rsp_valid one cycle after accept.
REQ-036 Write 8'h11 to 0x0000, 0x0002, 0x0004, 0x0006 (all banks/lanes at word 0 for NBANKS=4), read each -> 11, 0x0001/0x0003 -> 00.
REQ-037 Back-to-back: write 0x0100<-8'h3C, next-cycle read 0x0100 -> rsp_rdata=8'h3C; reads on 4 consecutive cycles -> 4 consecutive rsp_valid pulses, in order.
REQ-038 Assert rst_n low at INIT counter 5000 for 3 cycles -> outputs reset immediately; INIT lasts full 16384 cycles after release.
REQ-039 INIT_ZERO=0: write 0x2000<-8'h77, pulse reset, read 0x2000 -> 8'h77; req_ready=1 first edge after release.

Source files
------------

// File: rtl/ram_banked_pkg.sv
// Shared definitions for the banked SPRAM byte store.
//   SPRAM_AW / SPRAM_DW : word address and data width of one SPRAM bank
//   state_t             : controller state encoding (INIT zero-fill, RUN)
//   nbanks_legal()      : accepted values of the NBANKS parameter
//   lane_mask()         : byte lane -> SPRAM nibble write mask
package ram_banked_pkg;

    localparam int SPRAM_AW = 14;
    localparam int SPRAM_DW = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic bit nbanks_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4);
    endfunction

    // Each mask bit enables one nibble; a byte lane therefore owns two bits.
    function automatic logic [3:0] lane_mask(input logic lane);
        return lane ? 4'b1100 : 4'b0011;
    endfunction

endpackage

// File: rtl/SB_SPRAM256KA.sv
// Behavioural model of the iCE40UP 16K x 16 single-port RAM primitive.
// The vendor toolchain supplies the real cell; this model gives the
// same port-level behaviour for simulation and lint.
//   ADDRESS    : word address
//   DATAIN     : write data
//   MASKWREN   : per-nibble write enable (bit i -> DATAIN[4i+3:4i])
//   WREN       : 1 = write, 0 = read
//   CHIPSELECT : access enable
//   CLOCK      : clock, accesses on the rising edge
//   STANDBY    : hold, no access
//   SLEEP      : no access, output forced low
//   POWEROFF   : active-low power gate, output forced low
//   DATAOUT    : registered read data, holds between reads
module SB_SPRAM256KA (
    input  logic [13:0] ADDRESS,
    input  logic [15:0] DATAIN,
    input  logic [3:0]  MASKWREN,
    input  logic        WREN,
    input  logic        CHIPSELECT,
    input  logic        CLOCK,
    input  logic        STANDBY,
    input  logic        SLEEP,
    input  logic        POWEROFF,
    output logic [15:0] DATAOUT
);

    logic [15:0] mem [16384];
    logic [15:0] dout_q;
    logic        active;

    assign active = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF;

    // NOTE: the storage array has no reset; clearing RAM contents is a
    // controller job (zero-fill), not something a flop reset can do.
    always_ff @(posedge CLOCK) begin
        if (active) begin
            if (WREN) begin
                for (int i = 0; i < 4; i++) begin
                    if (MASKWREN[i]) mem[ADDRESS][4*i +: 4] <= DATAIN[4*i +: 4];
                end
            end else begin
                dout_q <= mem[ADDRESS];
            end
        end
    end

    assign DATAOUT = (SLEEP | ~POWEROFF) ? 16'h0000 : dout_q;

endmodule

// File: rtl/ram_bank.sv
// One 16K x 16 bank: a thin wrapper around a single SB_SPRAM256KA with
// the power controls tied to "always on".
//   clk   : clock
//   addr  : 14-bit word address
//   wdata : 16-bit write data
//   rdata : 16-bit registered read data
//   mask  : nibble write mask
//   we    : 1 = write, 0 = read
//   cs    : chip select
module ram_bank
    import ram_banked_pkg::*;
(
    input  logic                clk,
    input  logic [SPRAM_AW-1:0] addr,
    input  logic [SPRAM_DW-1:0] wdata,
    output logic [SPRAM_DW-1:0] rdata,
    input  logic [3:0]          mask,
    input  logic                we,
    input  logic                cs
);

    SB_SPRAM256KA u_spram (
        .ADDRESS   (addr),
        .DATAIN    (wdata),
        .MASKWREN  (mask),
        .WREN      (we),
        .CHIPSELECT(cs),
        .CLOCK     (clk),
        .STANDBY   (1'b0),
        .SLEEP     (1'b0),
        .POWEROFF  (1'b1),
        .DATAOUT   (rdata)
    );

endmodule

// File: rtl/ram_banked.sv
// Byte-addressed RAM built from NBANKS 16K x 16 SPRAM banks.
// Optionally zero-fills every bank after reset before taking requests.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : request present
//   req_ready   : request accepted this cycle when valid
//   req_we      : 1 = byte write, 0 = byte read
//   req_addr    : byte address {word, bank, lane}
//   req_wdata   : write byte
//   rsp_valid   : one-cycle pulse, read data available
//   rsp_rdata   : read byte, holds while rsp_valid is low
//   init_done   : controller is in RUN
module ram_banked
    import ram_banked_pkg::*;
#(
    parameter  int NBANKS    = 2,
    parameter  bit INIT_ZERO = 1'b1,
    localparam int BW        = $clog2(NBANKS),
    localparam int AW        = SPRAM_AW + 1 + BW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [7:0]    req_wdata,
    output logic          rsp_valid,
    output logic [7:0]    rsp_rdata,
    output logic          init_done
);

    localparam int                  BIW       = (BW > 0) ? BW : 1;
    localparam logic [SPRAM_AW-1:0] INIT_LAST = '1;

    if (!nbanks_legal(NBANKS)) begin : g_bad_nbanks
        $error("ram_banked: NBANKS must be 1, 2 or 4");
    end

    state_t              state;
    logic [SPRAM_AW-1:0] init_cnt;
    logic                ready_q;
    logic                done_q;
    logic                rsp_valid_q;
    logic [BIW-1:0]      cap_bank;
    logic                cap_lane;
    logic [7:0]          rdata_q;

    // Request address decode: {word, bank, lane}.
    logic                req_lane;
    logic [BIW-1:0]      req_bank;
    logic [SPRAM_AW-1:0] req_word;
    logic                accept;

    assign req_lane = req_addr[0];
    assign req_word = req_addr[AW-1:BW+1];
    if (BW == 0) begin : g_one_bank
        assign req_bank = '0;
    end else begin : g_multi_bank
        assign req_bank = req_addr[BW:1];
    end

    assign accept = req_valid & ready_q;

    // Shared bank drive; only chip select is per bank.
    logic [SPRAM_AW-1:0] mem_addr;
    logic [SPRAM_DW-1:0] mem_wdata;
    logic [3:0]          mem_mask;
    logic                mem_we;
    logic [NBANKS-1:0]   mem_cs;

    // NOTE: every signal gets a default at the top of always_comb so that
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_addr  = req_word;
        mem_wdata = {req_wdata, req_wdata};
        mem_mask  = lane_mask(req_lane);
        mem_we    = req_we;
        mem_cs    = '0;
        if (state == ST_INIT) begin
            mem_addr  = init_cnt;
            mem_wdata = '0;
            mem_mask  = 4'b1111;
            mem_we    = 1'b1;
            mem_cs    = '1;
        end else if (accept) begin
            mem_cs[req_bank] = 1'b1;
        end
    end

    logic [SPRAM_DW-1:0] bank_rdata [NBANKS];

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        ram_bank u_bank (
            .clk  (clk),
            .addr (mem_addr),
            .wdata(mem_wdata),
            .rdata(bank_rdata[b]),
            .mask (mem_mask),
            .we   (mem_we),
            .cs   (mem_cs[b])
        );
    end

    // The SPRAM output is already a register, so the byte picked with the
    // captured bank/lane is presented in the cycle right after accept; the
    // selected byte is registered into rdata_q so it holds afterwards.
    logic [SPRAM_DW-1:0] sel_word;
    logic [7:0]          sel_byte;

    assign sel_word = bank_rdata[cap_bank];
    assign sel_byte = cap_lane ? sel_word[15:8] : sel_word[7:0];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT_ZERO ? ST_INIT : ST_RUN;
            init_cnt    <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            cap_bank    <= '0;
            cap_lane    <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == INIT_LAST) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                end
                default: state <= ST_INIT;
            endcase

            rsp_valid_q <= accept & ~req_we;
            if (accept & ~req_we) begin
                cap_bank <= req_bank;
                cap_lane <= req_lane;
            end
            if (rsp_valid_q) rdata_q <= sel_byte;
        end
    end

    assign req_ready = ready_q;
    assign init_done = done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_valid_q ? sel_byte : rdata_q;

endmodule

// File: tb/tb_ram_banked.sv
// Directed bench for ram_banked: one zero-filling instance (NBANKS=2,
// INIT_ZERO=1) and one non-filling instance (INIT_ZERO=0).
module tb_ram_banked;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        init_done;

    logic        nz_rst_n;
    logic        nz_valid, nz_ready, nz_we;
    logic [15:0] nz_addr;
    logic [7:0]  nz_wdata;
    logic        nz_rsp_valid;
    logic [7:0]  nz_rsp_rdata;
    logic        nz_init_done;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    ram_banked #(.NBANKS(2), .INIT_ZERO(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .init_done(init_done)
    );

    ram_banked #(.NBANKS(2), .INIT_ZERO(1'b0)) dut_nz (
        .clk      (clk),
        .rst_n    (nz_rst_n),
        .req_valid(nz_valid),
        .req_ready(nz_ready),
        .req_we   (nz_we),
        .req_addr (nz_addr),
        .req_wdata(nz_wdata),
        .rsp_valid(nz_rsp_valid),
        .rsp_rdata(nz_rsp_rdata),
        .init_done(nz_init_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
        tick();
        req_valid = 1'b0;
        check($sformatf("no rsp after write %h", addr), {31'b0, rsp_valid}, 32'd0);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [7:0] exp);
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
        tick();
        req_valid = 1'b0;
        check($sformatf("rsp_valid read %h", addr), {31'b0, rsp_valid}, 32'd1);
        check($sformatf("rdata read %h", addr), {24'b0, rsp_rdata}, {24'b0, exp});
    endtask

    // Count edges from reset release until req_ready rises, with a read
    // request held the whole time to show it is ignored.
    task automatic wait_ready(input string tag);
        int n;
        bit saw_rsp;
        n = 0;
        saw_rsp = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040;
        while (req_ready !== 1'b1 && n < 20000) begin
            tick();
            n++;
            if (rsp_valid === 1'b1) saw_rsp = 1'b1;
            if (n == 100) check({tag, " init_done low in INIT"}, {31'b0, init_done}, 32'd0);
        end
        req_valid = 1'b0;
        check({tag, " INIT length"}, n, 32'd16384);
        check({tag, " init_done in RUN"}, {31'b0, init_done}, 32'd1);
        check({tag, " request ignored in INIT"}, {31'b0, saw_rsp}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, {31'b0, req_ready}, 32'd0);
        check({tag, " init_done"}, {31'b0, init_done}, 32'd0);
        check({tag, " rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, " rsp_rdata"}, {24'b0, rsp_rdata}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        nz_rst_n = 1'b0; nz_valid = 1'b0; nz_we = 1'b0; nz_addr = '0; nz_wdata = '0;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset");

        // Zero-fill, then reads of low/mid/high addresses
        rst_n = 1'b1;
        wait_ready("init1");
        do_read(16'h0000, 8'h00);
        do_read(16'h7FFF, 8'h00);
        do_read(16'hFFFF, 8'h00);

        // Byte lanes of one word
        do_write(16'h1234, 8'hA5);
        do_write(16'h1235, 8'h5A);
        do_read(16'h1234, 8'hA5);
        do_read(16'h1235, 8'h5A);

        // Both banks, low lane, words 0 and 1; high lanes stay zero
        do_write(16'h0000, 8'h11);
        do_write(16'h0002, 8'h11);
        do_write(16'h0004, 8'h11);
        do_write(16'h0006, 8'h11);
        do_read(16'h0000, 8'h11);
        do_read(16'h0002, 8'h11);
        do_read(16'h0004, 8'h11);
        do_read(16'h0006, 8'h11);
        do_read(16'h0001, 8'h00);
        do_read(16'h0003, 8'h00);

        // Write then read of the same byte on the next cycle
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0100; req_wdata = 8'h3C;
        tick();
        check("no rsp after b2b write", {31'b0, rsp_valid}, 32'd0);
        req_we = 1'b0;
        tick();
        check("b2b raw rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("b2b raw rdata", {24'b0, rsp_rdata}, 32'h3C);

        // Four reads on consecutive cycles
        req_addr = 16'h1234; tick();
        check("burst0 valid", {31'b0, rsp_valid}, 32'd1);
        check("burst0 data", {24'b0, rsp_rdata}, 32'hA5);
        req_addr = 16'h1235; tick();
        check("burst1 valid", {31'b0, rsp_valid}, 32'd1);
        check("burst1 data", {24'b0, rsp_rdata}, 32'h5A);
        req_addr = 16'h0002; tick();
        check("burst2 valid", {31'b0, rsp_valid}, 32'd1);
        check("burst2 data", {24'b0, rsp_rdata}, 32'h11);
        req_addr = 16'h0100; tick();
        check("burst3 valid", {31'b0, rsp_valid}, 32'd1);
        check("burst3 data", {24'b0, rsp_rdata}, 32'h3C);
        req_valid = 1'b0;
        tick();
        check("idle rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("idle rdata hold", {24'b0, rsp_rdata}, 32'h3C);
        repeat (2) tick();
        check("idle rdata hold later", {24'b0, rsp_rdata}, 32'h3C);

        // Reset during RUN clears outputs without waiting for an edge
        rst_n = 1'b0;
        #1;
        check_reset_outputs("run reset");
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset again at init counter 5000
        repeat (5000) tick();
        check("mid-init ready low", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-init reset");
        repeat (3) tick();
        rst_n = 1'b1;
        wait_ready("init2");

        // Memory was re-zeroed
        do_read(16'h1234, 8'h00);
        do_read(16'h1235, 8'h00);
        do_read(16'h0100, 8'h00);

        // Non-filling instance: contents survive reset
        nz_rst_n = 1'b1;
        check("nz ready before first edge", {31'b0, nz_ready}, 32'd0);
        tick();
        check("nz ready first edge", {31'b0, nz_ready}, 32'd1);
        check("nz init_done", {31'b0, nz_init_done}, 32'd1);
        nz_valid = 1'b1; nz_we = 1'b1; nz_addr = 16'h2000; nz_wdata = 8'h77;
        tick();
        nz_valid = 1'b0;
        nz_rst_n = 1'b0;
        #1;
        check("nz reset ready", {31'b0, nz_ready}, 32'd0);
        repeat (3) tick();
        nz_rst_n = 1'b1;
        tick();
        check("nz ready after pulse", {31'b0, nz_ready}, 32'd1);
        nz_valid = 1'b1; nz_we = 1'b0; nz_addr = 16'h2000;
        tick();
        nz_valid = 1'b0;
        check("nz rsp_valid", {31'b0, nz_rsp_valid}, 32'd1);
        check("nz data kept", {24'b0, nz_rsp_rdata}, 32'h77);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
